// File: rtl/spdif_subframe_decoder.sv
// S/PDIF subframe decoder: turns edge-interval classes (1/2/3 UI) into preambles,
// biphase-mark data and 28-slot subframes, with parity check and lock tracking.
module spdif_subframe_decoder #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ena,
  input  logic        i_shift_ena,
  input  logic        i_short,
  input  logic        i_mid,
  input  logic        i_long,
  output logic [23:0] o_sample,
  output logic        o_v,
  output logic        o_u,
  output logic        o_c,
  output logic        o_parity_err,
  output logic        o_channel,
  output logic        o_block_start,
  output logic        o_valid,
  output logic        o_sync_err,
  output logic        o_locked
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [3:0] {HUNT, P1, B2, B3, M2, M3, W2, W3, DATA} state_t;

  state_t      state;
  state_t      nxt;
  logic [27:0] shreg;
  logic [27:0] new_sr;
  logic [4:0]  bit_cnt;
  logic        half;
  logic        par;
  logic        new_par;
  logic [3:0]  good_cnt;
  logic        last_chan;
  logic        chan;
  logic        blk;
  logic        ev;
  logic        legal;
  logic        bad;
  logic        go_data;
  logic        nchan;
  logic        nblk;
  logic        do_shift;
  logic        set_half;
  logic        bitv;
  logic        done;

  assign ev      = i_ena & i_shift_ena;
  // exactly one class bit: odd count but not all three
  assign legal   = (i_short ^ i_mid ^ i_long) & ~(i_short & i_mid & i_long);
  assign new_sr  = {bitv, shreg[27:1]};
  assign new_par = par ^ bitv;
  assign done    = do_shift && (bit_cnt == 5'd27);

  always_comb begin
    nxt      = state;
    bad      = 1'b0;
    go_data  = 1'b0;
    nchan    = 1'b0;
    nblk     = 1'b0;
    do_shift = 1'b0;
    set_half = 1'b0;
    bitv     = 1'b0;
    if (ev) begin
      if (state == HUNT) begin
        if (legal && i_long) nxt = P1;
        else                 nxt = HUNT;
      end else if (!legal) begin
        bad = 1'b1;
      end else begin
        case (state)
          P1: begin
            if (i_short)     nxt = B2;
            else if (i_long) nxt = M2;
            else             nxt = W2;
          end
          B2: if (i_short) nxt = B3; else bad = 1'b1;
          B3: begin
            if (i_long) begin go_data = 1'b1; nchan = 1'b0; nblk = 1'b1; end
            else        bad = 1'b1;
          end
          M2: if (i_short) nxt = M3; else bad = 1'b1;
          M3: begin
            if (i_short) begin go_data = 1'b1; nchan = 1'b0; nblk = 1'b0; end
            else         bad = 1'b1;
          end
          W2: if (i_short) nxt = W3; else bad = 1'b1;
          W3: begin
            if (i_mid) begin go_data = 1'b1; nchan = 1'b1; nblk = 1'b0; end
            else       bad = 1'b1;
          end
          DATA: begin
            if (!half) begin
              if (i_mid)        begin do_shift = 1'b1; bitv = 1'b0; end
              else if (i_short) set_half = 1'b1;
              else              bad = 1'b1;
            end else begin
              if (i_short) begin do_shift = 1'b1; bitv = 1'b1; end
              else         bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      // once locked, channels must alternate A/B
      if (go_data && o_locked && (nchan == last_chan)) begin
        go_data = 1'b0;
        bad     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= HUNT;
      shreg         <= 28'd0;
      bit_cnt       <= 5'd0;
      half          <= 1'b0;
      par           <= 1'b0;
      good_cnt      <= 4'd0;
      last_chan     <= 1'b0;
      chan          <= 1'b0;
      blk           <= 1'b0;
      o_sample      <= 24'd0;
      o_v           <= 1'b0;
      o_u           <= 1'b0;
      o_c           <= 1'b0;
      o_parity_err  <= 1'b0;
      o_channel     <= 1'b0;
      o_block_start <= 1'b0;
      o_valid       <= 1'b0;
      o_sync_err    <= 1'b0;
      o_locked      <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_sync_err <= 1'b0;
      if (ev) begin
        if (bad) begin
          state      <= HUNT;
          half       <= 1'b0;
          bit_cnt    <= 5'd0;
          good_cnt   <= 4'd0;
          o_locked   <= 1'b0;
          o_sync_err <= 1'b1;
        end else if (go_data) begin
          state   <= DATA;
          bit_cnt <= 5'd0;
          half    <= 1'b0;
          par     <= 1'b0;
          chan    <= nchan;
          blk     <= nblk;
        end else if (state == DATA) begin
          if (do_shift) begin
            shreg   <= new_sr;
            par     <= new_par;
            half    <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            if (done) begin
              state         <= HUNT;
              bit_cnt       <= 5'd0;
              o_sample      <= new_sr[23:0];
              o_v           <= new_sr[24];
              o_u           <= new_sr[25];
              o_c           <= new_sr[26];
              o_parity_err  <= new_par;
              o_channel     <= chan;
              o_block_start <= blk;
              o_valid       <= 1'b1;
              last_chan     <= chan;
              if (new_par) begin
                good_cnt <= 4'd0;
                o_locked <= 1'b0;
              end else if (good_cnt < LOCK_N) begin
                good_cnt <= good_cnt + 4'd1;
                o_locked <= ((good_cnt + 4'd1) == LOCK_N);
              end else begin
                o_locked <= 1'b1;
              end
            end
          end else if (set_half) begin
            half <= 1'b1;
          end else begin
            half <= half;
          end
        end else begin
          state <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
// Directed bench for spdif_subframe_decoder: builds biphase interval streams
// for B/M/W subframes and checks decode, parity, sync errors and lock.
module tb_spdif_subframe_decoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ena = 1'b1;
  logic        i_shift_ena = 1'b0;
  logic        i_short = 1'b0;
  logic        i_mid = 1'b0;
  logic        i_long = 1'b0;
  logic [23:0] o_sample;
  logic        o_v, o_u, o_c, o_parity_err, o_channel, o_block_start;
  logic        o_valid, o_sync_err, o_locked;

  int checks = 0;
  int errors = 0;

  spdif_subframe_decoder #(.LOCK_FRAMES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_shift_ena(i_shift_ena),
    .i_short(i_short), .i_mid(i_mid), .i_long(i_long),
    .o_sample(o_sample), .o_v(o_v), .o_u(o_u), .o_c(o_c),
    .o_parity_err(o_parity_err), .o_channel(o_channel),
    .o_block_start(o_block_start), .o_valid(o_valid),
    .o_sync_err(o_sync_err), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one event per cycle: drive at negedge, release just after posedge
  task automatic ev(input logic s, input logic m, input logic l);
    @(negedge i_clk);
    i_shift_ena = 1'b1; i_short = s; i_mid = m; i_long = l;
    @(posedge i_clk);
    #1;
    i_shift_ena = 1'b0; i_short = 1'b0; i_mid = 1'b0; i_long = 1'b0;
  endtask

  task automatic iv(input int ui);
    if (ui == 1)      ev(1'b1, 1'b0, 1'b0);
    else if (ui == 2) ev(1'b0, 1'b1, 1'b0);
    else              ev(1'b0, 1'b0, 1'b1);
  endtask

  // 0 = B (3,1,1,3), 1 = M (3,3,1,1), 2 = W (3,2,1,2)
  task automatic send_pre(input int pre);
    iv(3);
    if (pre == 0)      begin iv(1); iv(1); iv(3); end
    else if (pre == 1) begin iv(3); iv(1); iv(1); end
    else               begin iv(2); iv(1); iv(2); end
  endtask

  task automatic send_bits(input logic [27:0] slots, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (slots[i]) begin iv(1); iv(1); end
      else          iv(2);
    end
  endtask

  function automatic logic [27:0] mk(input logic [23:0] smp, input logic v,
                                     input logic u, input logic c, input logic flip);
    logic [26:0] d;
    d = {c, u, v, smp};
    return {(^d) ^ flip, d};
  endfunction

  task automatic frame(input int pre, input logic [27:0] slots);
    send_pre(pre);
    send_bits(slots, 0, 27);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] smp, input logic u,
                             input logic ch, input logic blk, input logic perr,
                             input logic lock);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_sample"}, {8'd0, o_sample}, {8'd0, smp});
    check({tag, "_u"}, {31'd0, o_u}, {31'd0, u});
    check({tag, "_chan"}, {31'd0, o_channel}, {31'd0, ch});
    check({tag, "_blk"}, {31'd0, o_block_start}, {31'd0, blk});
    check({tag, "_perr"}, {31'd0, o_parity_err}, {31'd0, perr});
    check({tag, "_lock"}, {31'd0, o_locked}, {31'd0, lock});
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_sample", {8'd0, o_sample}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_lock", {31'd0, o_locked}, 32'd0);
    i_rst = 1'b0;

    // B frame, then single-cycle o_valid
    frame(0, mk(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0));
    check_frame("b1", 24'h123456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b1_v", {31'd0, o_v}, 32'd0);
    check("b1_c", {31'd0, o_c}, 32'd0);
    @(posedge i_clk); #1;
    check("b1_pulse", {31'd0, o_valid}, 32'd0);
    check("b1_hold", {8'd0, o_sample}, 32'h00123456);

    // M then W: lock rises on 2nd good frame
    frame(1, mk(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    check_frame("m1", 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(2, mk(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0));
    check_frame("w1", 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("w1_v", {31'd0, o_v}, 32'd1);
    check("w1_c", {31'd0, o_c}, 32'd1);

    // parity error drops lock, relock after two good frames
    frame(0, mk(24'h0F0F01, 1'b0, 1'b0, 1'b0, 1'b1));
    check_frame("perr", 24'h0F0F01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(2, mk(24'h800001, 1'b0, 1'b1, 1'b0, 1'b0));
    check_frame("rl1", 24'h800001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(1, mk(24'h00A5A5, 1'b0, 1'b0, 1'b1, 1'b0));
    check_frame("rl2", 24'h00A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // long in DATA after 10 bits
    send_pre(2);
    send_bits(mk(24'h3C3C3C, 1'b0, 1'b0, 1'b0, 1'b0), 0, 9);
    iv(3);
    check("se_long_err", {31'd0, o_sync_err}, 32'd1);
    check("se_long_valid", {31'd0, o_valid}, 32'd0);
    check("se_long_lock", {31'd0, o_locked}, 32'd0);
    @(posedge i_clk); #1;
    check("se_long_pulse", {31'd0, o_sync_err}, 32'd0);
    frame(0, mk(24'hABCDEF, 1'b1, 1'b0, 1'b1, 1'b0));
    check_frame("after_se", 24'hABCDEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // short then mid in DATA
    send_pre(1);
    iv(1); iv(2);
    check("se_short_mid", {31'd0, o_sync_err}, 32'd1);
    // two class bits at once in DATA
    send_pre(1);
    send_bits(28'h0000005, 0, 3);
    ev(1'b1, 1'b1, 1'b0);
    check("se_multi", {31'd0, o_sync_err}, 32'd1);
    // no class bit in HUNT is ignored
    ev(1'b0, 1'b0, 1'b0);
    check("hunt_none", {31'd0, o_sync_err}, 32'd0);

    // clock-enable freeze mid-frame, including events presented while disabled
    send_pre(0);
    send_bits(mk(24'h5A17C3, 1'b1, 1'b1, 1'b0, 1'b0), 0, 9);
    i_ena = 1'b0;
    ev(1'b0, 1'b0, 1'b1);
    ev(1'b1, 1'b1, 1'b1);
    repeat (48) @(posedge i_clk);
    i_ena = 1'b1;
    send_bits(mk(24'h5A17C3, 1'b1, 1'b1, 1'b0, 1'b0), 10, 27);
    check_frame("ena", 24'h5A17C3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // lock, then two channel-A subframes in a row
    frame(2, mk(24'h654321, 1'b0, 1'b0, 1'b0, 1'b0));
    check_frame("alt_w", 24'h654321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(1, mk(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0));
    check_frame("alt_m", 24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pre(1);
    check("alt_err", {31'd0, o_sync_err}, 32'd1);
    check("alt_lock", {31'd0, o_locked}, 32'd0);

    // async reset mid-frame
    send_pre(2);
    send_bits(28'h00000FF, 0, 4);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("rst_mid_sample", {8'd0, o_sample}, 32'd0);
    check("rst_mid_chan", {31'd0, o_channel}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    frame(1, mk(24'h0000C8, 1'b0, 1'b1, 1'b1, 1'b0));
    check_frame("post_rst", 24'h0000C8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
